// File: rtl/relu_layer.sv
// relu_layer: element-wise ReLU stage with per-sample positive mask.
//   Forward run : q_forward[e]  = max(d_forward[e], 0); mask[e] = d_forward[e] > 0.
//   Backward run: q_backward[e] = bwd_mask[e] ? d_backward[e] : 0.
//   Two mask slots (fwd_mask, bwd_mask) let forward(k+1) overlap backward(k).
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   run_forward / run_backward      level requests, held until matching valid seen
//   load_backward                   1-cycle pulse: bwd_mask <= fwd_mask
//   state_forward / state_backward  phase codes gating run acceptance
//   d_forward / d_backward          N packed signed N_LEN-bit elements
//   valid_forward / valid_backward  result complete, held while run is high
//   q_forward / q_backward          registered results
module relu_layer #(
  parameter int unsigned HID_DIM   = 4,
  parameter int unsigned N_LEN     = 16,
  parameter int unsigned STATE_LEN = 4,
  parameter logic [STATE_LEN-1:0] F_STATE = STATE_LEN'(3),
  parameter logic [STATE_LEN-1:0] B_STATE = STATE_LEN'(5),
  parameter int unsigned PAR       = HID_DIM
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               run_forward,
  input  logic                               run_backward,
  input  logic                               load_backward,
  input  logic [STATE_LEN-1:0]               state_forward,
  input  logic [STATE_LEN-1:0]               state_backward,
  input  logic [HID_DIM*HID_DIM*N_LEN-1:0]   d_forward,
  input  logic [HID_DIM*HID_DIM*N_LEN-1:0]   d_backward,
  output logic                               valid_forward,
  output logic                               valid_backward,
  output logic [HID_DIM*HID_DIM*N_LEN-1:0]   q_forward,
  output logic [HID_DIM*HID_DIM*N_LEN-1:0]   q_backward
);

  localparam int unsigned N  = HID_DIM * HID_DIM;
  localparam int unsigned C  = N / PAR;
  localparam int unsigned DW = N * N_LEN;
  localparam int unsigned CW = (C > 1) ? $clog2(C) : 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(C - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e          f_state_q, b_state_q;
  logic [CW-1:0]   f_cnt_q, b_cnt_q;
  logic            f_valid_q, b_valid_q;
  logic [DW-1:0]   q_fwd_q, q_bwd_q;
  logic [DW-1:0]   q_fwd_d, q_bwd_d;
  logic [N-1:0]    f_shadow_q, f_shadow_d;
  logic [N-1:0]    fwd_mask_q, bwd_mask_q;

  // Per-element next values; only the element's own slice updates, others hold.
  for (genvar e = 0; e < N; e++) begin : g_elem
    localparam logic [CW-1:0] SLICE = CW'(e / PAR);
    logic [N_LEN-1:0] df, db;
    logic             f_hit, b_hit;

    assign df    = d_forward[e*N_LEN +: N_LEN];
    assign db    = d_backward[e*N_LEN +: N_LEN];
    assign f_hit = (f_cnt_q == SLICE);
    assign b_hit = (b_cnt_q == SLICE);

    assign q_fwd_d[e*N_LEN +: N_LEN] =
      f_hit ? (df[N_LEN-1] ? '0 : df) : q_fwd_q[e*N_LEN +: N_LEN];
    // Zero is not "positive": its mask bit is 0.
    assign f_shadow_d[e] =
      f_hit ? ((df != '0) && !df[N_LEN-1]) : f_shadow_q[e];
    assign q_bwd_d[e*N_LEN +: N_LEN] =
      b_hit ? (bwd_mask_q[e] ? db : '0) : q_bwd_q[e*N_LEN +: N_LEN];
  end

  // Forward FSM: slice-wise ReLU, commits the sample mask on the last slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_state_q  <= S_IDLE;
      f_cnt_q    <= '0;
      f_valid_q  <= 1'b0;
      q_fwd_q    <= '0;
      f_shadow_q <= '0;
      fwd_mask_q <= '0;
    end else begin
      case (f_state_q)
        S_IDLE: begin
          if (run_forward && (state_forward == F_STATE)) begin
            f_state_q <= S_BUSY;
            f_cnt_q   <= '0;
          end
        end
        S_BUSY: begin
          q_fwd_q    <= q_fwd_d;
          f_shadow_q <= f_shadow_d;
          if (f_cnt_q == LAST_SLICE) begin
            fwd_mask_q <= f_shadow_d;
            f_state_q  <= S_DONE;
          end else begin
            f_cnt_q <= f_cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          if (run_forward) begin
            f_valid_q <= 1'b1;
          end else begin
            f_valid_q <= 1'b0;
            f_state_q <= S_IDLE;
          end
        end
        default: f_state_q <= S_IDLE;
      endcase
    end
  end

  // Backward FSM plus the backward mask slot; the slot is frozen while BUSY so a
  // run always gates with one consistent mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_state_q  <= S_IDLE;
      b_cnt_q    <= '0;
      b_valid_q  <= 1'b0;
      q_bwd_q    <= '0;
      bwd_mask_q <= '0;
    end else begin
      if (load_backward && (b_state_q != S_BUSY)) begin
        bwd_mask_q <= fwd_mask_q;
      end
      case (b_state_q)
        S_IDLE: begin
          if (run_backward && (state_backward == B_STATE)) begin
            b_state_q <= S_BUSY;
            b_cnt_q   <= '0;
          end
        end
        S_BUSY: begin
          q_bwd_q <= q_bwd_d;
          if (b_cnt_q == LAST_SLICE) begin
            b_state_q <= S_DONE;
          end else begin
            b_cnt_q <= b_cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          if (run_backward) begin
            b_valid_q <= 1'b1;
          end else begin
            b_valid_q <= 1'b0;
            b_state_q <= S_IDLE;
          end
        end
        default: b_state_q <= S_IDLE;
      endcase
    end
  end

  assign valid_forward  = f_valid_q;
  assign valid_backward = b_valid_q;
  assign q_forward      = q_fwd_q;
  assign q_backward     = q_bwd_q;

endmodule

// File: tb/tb_relu_layer.sv
// tb_relu_layer: scoreboard bench for relu_layer (HID_DIM=4, N_LEN=16, PAR=4 -> C=4).
`timescale 1ns/1ps
module tb_relu_layer;

  localparam int unsigned HID_DIM   = 4;
  localparam int unsigned N_LEN     = 16;
  localparam int unsigned STATE_LEN = 4;
  localparam int unsigned N         = HID_DIM * HID_DIM;
  localparam int unsigned C         = N / HID_DIM;
  localparam int unsigned DW        = N * N_LEN;
  localparam logic [STATE_LEN-1:0] F_ST = 4'd3;
  localparam logic [STATE_LEN-1:0] B_ST = 4'd5;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 run_forward, run_backward, load_backward;
  logic [STATE_LEN-1:0] state_forward, state_backward;
  logic [DW-1:0]        d_forward, d_backward;
  logic                 valid_forward, valid_backward;
  logic [DW-1:0]        q_forward, q_backward;

  relu_layer #(
    .HID_DIM(HID_DIM), .N_LEN(N_LEN), .STATE_LEN(STATE_LEN),
    .F_STATE(F_ST), .B_STATE(B_ST), .PAR(HID_DIM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .run_forward(run_forward), .run_backward(run_backward),
    .load_backward(load_backward),
    .state_forward(state_forward), .state_backward(state_backward),
    .d_forward(d_forward), .d_backward(d_backward),
    .valid_forward(valid_forward), .valid_backward(valid_backward),
    .q_forward(q_forward), .q_backward(q_backward)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_f_q[$];
  logic [DW-1:0] exp_b_q[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Element e takes pattern[e % 4].
  function automatic logic [DW-1:0] pat4(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c, input logic [15:0] d);
    logic [DW-1:0] v;
    logic [15:0]   t[4];
    t[0] = a; t[1] = b; t[2] = c; t[3] = d;
    v = '0;
    for (int e = 0; e < N; e++) v[e*N_LEN +: N_LEN] = t[e % 4];
    return v;
  endfunction

  // Monitor: compare against the scoreboard on every rising valid.
  logic pf = 1'b0, pb = 1'b0;
  always @(negedge clk) begin
    if (valid_forward && !pf) begin
      if (exp_f_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL fwd_unexpected_valid: got q_forward %h with no expectation", q_forward);
      end else begin
        check("q_forward", q_forward, exp_f_q.pop_front());
      end
    end
    if (valid_backward && !pb) begin
      if (exp_b_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL bwd_unexpected_valid: got q_backward %h with no expectation", q_backward);
      end else begin
        check("q_backward", q_backward, exp_b_q.pop_front());
      end
    end
    pf <= valid_forward;
    pb <= valid_backward;
  end

  // One full request/valid handshake with latency and drop checks.
  task automatic do_run(input bit fwd, input logic [DW-1:0] d, input string tag);
    int lat;
    bit seen;
    @(negedge clk);
    if (fwd) begin d_forward = d; state_forward = F_ST; run_forward = 1'b1; end
    else     begin d_backward = d; state_backward = B_ST; run_backward = 1'b1; end
    @(posedge clk);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      seen = fwd ? valid_forward : valid_backward;
    end
    check({tag, "_latency"}, DW'(lat), DW'(C + 1));
    @(negedge clk);
    check({tag, "_valid_held"}, DW'(fwd ? valid_forward : valid_backward), DW'(seen));
    if (fwd) run_forward = 1'b0; else run_backward = 1'b0;
    @(posedge clk); #1;
    check({tag, "_valid_drop"}, DW'(fwd ? valid_forward : valid_backward), DW'(0));
  endtask

  task automatic pulse_load();
    @(negedge clk); load_backward = 1'b1;
    @(negedge clk); load_backward = 1'b0;
  endtask

  logic [DW-1:0] p_a, q_a;
  bit            bad;

  initial begin
    rst_n = 1'b0; run_forward = 1'b0; run_backward = 1'b0; load_backward = 1'b0;
    state_forward = '0; state_backward = '0; d_forward = '0; d_backward = '0;
    p_a = pat4(16'h0100, 16'hFF00, 16'h0000, 16'h7FFF);
    q_a = pat4(16'h0100, 16'h0000, 16'h0000, 16'h7FFF);

    // Test 1: reset state, then wrong-state requests are ignored.
    #2;
    check("rst_q_forward", q_forward, '0);
    check("rst_q_backward", q_backward, '0);
    check("rst_valids", DW'({valid_forward, valid_backward}), DW'(0));
    @(negedge clk); rst_n = 1'b1;
    d_forward = p_a; d_backward = pat4(16'h0010, 16'h0010, 16'h0010, 16'h0010);
    state_forward = 4'd7; state_backward = 4'd2;
    run_forward = 1'b1; run_backward = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (valid_forward || valid_backward) bad = 1'b1;
    end
    check("wrong_state_no_valid", DW'(bad), DW'(0));
    check("wrong_state_q_hold", q_forward, '0);
    run_forward = 1'b0; run_backward = 1'b0;
    repeat (2) @(negedge clk);

    // Test 2: forward pattern.
    exp_f_q.push_back(q_a);
    do_run(1'b1, p_a, "t2_fwd");

    // Test 3: load then backward gated by mask {1,0,0,1}.
    pulse_load();
    exp_b_q.push_back(pat4(16'h0010, 16'h0000, 16'h0000, 16'h0010));
    do_run(1'b0, pat4(16'h0010, 16'h0010, 16'h0010, 16'h0010), "t3_bwd");

    // Test 4: overlap forward(B, all negative) with backward(A).
    pulse_load();
    exp_f_q.push_back('0);
    exp_b_q.push_back(pat4(16'h0005, 16'h0000, 16'h0000, 16'h0005));
    fork
      do_run(1'b1, pat4(16'hFFFF, 16'h8000, 16'h8001, 16'hFF00), "t4_fwd");
      do_run(1'b0, pat4(16'h0005, 16'h0005, 16'h0005, 16'h0005), "t4_bwd");
    join
    pulse_load();
    exp_b_q.push_back('0);
    do_run(1'b0, pat4(16'h0005, 16'h0005, 16'h0005, 16'h0005), "t4_bwd_b");

    // Test 5a: forward all-positive D, then forward A with load on the commit edge.
    exp_f_q.push_back(pat4(16'h0001, 16'h0001, 16'h0001, 16'h0001));
    do_run(1'b1, pat4(16'h0001, 16'h0001, 16'h0001, 16'h0001), "t5_fwd_d");
    exp_f_q.push_back(q_a);
    fork
      do_run(1'b1, p_a, "t5_fwd_a");
      begin
        @(negedge clk); @(posedge clk);
        repeat (C - 1) @(posedge clk);
        @(negedge clk); load_backward = 1'b1;
        @(negedge clk); load_backward = 1'b0;
      end
    join
    exp_b_q.push_back(pat4(16'h0005, 16'h0005, 16'h0005, 16'h0005));
    do_run(1'b0, pat4(16'h0005, 16'h0005, 16'h0005, 16'h0005), "t5_bwd_commit");

    // Test 5b: load during backward BUSY leaves the mask (all ones) untouched.
    exp_b_q.push_back(pat4(16'h0007, 16'h0007, 16'h0007, 16'h0007));
    fork
      do_run(1'b0, pat4(16'h0007, 16'h0007, 16'h0007, 16'h0007), "t5_bwd_busy");
      begin
        @(negedge clk); @(posedge clk); @(posedge clk);
        @(negedge clk); load_backward = 1'b1;
        @(negedge clk); load_backward = 1'b0;
      end
    join
    exp_b_q.push_back(pat4(16'h0009, 16'h0009, 16'h0009, 16'h0009));
    do_run(1'b0, pat4(16'h0009, 16'h0009, 16'h0009, 16'h0009), "t5_bwd_after");

    // Test 6: async reset in the middle of a forward run.
    @(negedge clk);
    d_forward = pat4(16'h0002, 16'h0002, 16'h0002, 16'h0002);
    state_forward = F_ST; run_forward = 1'b1;
    @(posedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b0; #1;
    check("t6_rst_q_forward", q_forward, '0);
    check("t6_rst_q_backward", q_backward, '0);
    check("t6_rst_valids", DW'({valid_forward, valid_backward}), DW'(0));
    run_forward = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    exp_f_q.push_back(q_a);
    do_run(1'b1, p_a, "t6_fwd_fresh");
    exp_b_q.push_back('0);
    do_run(1'b0, pat4(16'h0010, 16'h0010, 16'h0010, 16'h0010), "t6_bwd_nomask");
    pulse_load();
    exp_b_q.push_back(pat4(16'h0010, 16'h0000, 16'h0000, 16'h0010));
    do_run(1'b0, pat4(16'h0010, 16'h0010, 16'h0010, 16'h0010), "t6_bwd_loaded");

    repeat (3) @(negedge clk);
    check("sb_drain_fwd", DW'(exp_f_q.size()), DW'(0));
    check("sb_drain_bwd", DW'(exp_b_q.size()), DW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
